// File: rtl/decoder_index_sequencer_if.sv
// Handshake/bus bundle for decoder_index_sequencer.
// master drives start/stop/cont/lo/hi; slave drives ip/en/busy/done.
interface decoder_index_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             stop;
  logic             cont;
  logic [IDX_W-1:0] lo;
  logic [IDX_W-1:0] hi;
  logic [IDX_W-1:0] ip;
  logic             en;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, cont, lo, hi,
    input  ip, en, busy, done
  );

  modport slave (
    input  start, stop, cont, lo, hi,
    output ip, en, busy, done
  );
endinterface

// File: rtl/decoder_index_sequencer.sv
// Index/enable sequencer feeding a 4-to-16 decoder: sweeps ip over lo..hi,
// holding each index DWELL cycles, single or continuous sweeps.
// Ports: clk, rst (sync, active-high), bus (slave): start/stop/cont/lo/hi in;
//   ip/en/busy/done out, all registered.
// Option: define SEQ_GAP_EN for one en=0 cycle between indices.
module decoder_index_sequencer #(
  parameter int IDX_W   = 4,
  parameter int DWELL   = 20,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst,
  decoder_index_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [IDX_W-1:0]   lo_q;
  logic [IDX_W-1:0]   hi_q;
  logic               cont_q;
  logic [IDX_W-1:0]   ip;
  logic               en;
  logic               busy;
  logic               done;

  assign bus.ip   = ip;
  assign bus.en   = en;
  assign bus.busy = busy;
  assign bus.done = done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      cont_q <= 1'b0;
      ip     <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            lo_q   <= bus.lo;
            hi_q   <= bus.hi;
            cont_q <= bus.cont;
            ip     <= bus.lo;
            en     <= 1'b1;
            busy   <= 1'b1;
            cnt    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // stop wins over dwell expiry
          if (bus.stop) begin
            en    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == LAST) begin
            if (ip != hi_q || cont_q) begin
              ip  <= (ip != hi_q) ? ip + IDX_W'(1) : lo_q;
              cnt <= '0;
`ifdef SEQ_GAP_EN
              en    <= 1'b0;
              state <= GAP;
`endif
            end else begin
              en    <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
`ifdef SEQ_GAP_EN
        GAP: begin
          if (bus.stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            en    <= 1'b1;
            cnt   <= '0;
            state <= SCAN;
          end
        end
`endif
        default: begin
          en    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
